// File: rtl/imem_stream_loader.sv
// Boot loader: turns a length-prefixed byte stream into instruction
// memory word writes and holds the core in reset until the image is in.
module imem_stream_loader #(
  parameter int ADDR_WIDTH = 8,
  parameter int START_ADDR = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  cpu_hold,
  output logic                  done,
  output logic                  overflow
);

  typedef enum logic [2:0] {
    IDLE,
    LEN_LO,
    LEN_HI,
    DATA,
    WRITE,
    DONE
  } state_t;

  localparam int unsigned DEPTH = 32'd1 << ADDR_WIDTH;
  localparam int unsigned CAP   = DEPTH - START_ADDR;
  localparam logic [ADDR_WIDTH-1:0] ADDR_INIT =
    ADDR_WIDTH'(START_ADDR);
  localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = '1;

  state_t                  state;
  state_t                  state_n;
  logic [15:0]             len_q;
  logic [15:0]             word_cnt;
  logic [1:0]              byte_cnt;
  logic [31:0]             wdata_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic                    hold_q;
  logic                    done_q;
  logic                    ovf_q;

  logic [15:0] len_hdr;
  logic        last_word;
  logic        in_cap;
  logic        hdr_ovf;
  logic        load;

  assign len_hdr   = {in_data, len_q[7:0]};
  assign last_word = ({1'b0, word_cnt} + 17'd1) == {1'b0, len_q};
  assign in_cap    = {16'h0, word_cnt} < CAP;
  assign hdr_ovf   = {16'h0, len_hdr} > CAP;
  assign load      = start & ((state == IDLE) | (state == DONE));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n  = state;
    in_ready = 1'b0;
    imem_we  = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) state_n = LEN_LO;
      end
      LEN_LO: begin
        in_ready = 1'b1;
        if (in_valid) state_n = LEN_HI;
      end
      LEN_HI: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_n = (len_hdr == 16'h0) ? DONE : DATA;
        end
      end
      DATA: begin
        in_ready = 1'b1;
        if (in_valid && byte_cnt == 2'd3) state_n = WRITE;
      end
      WRITE: begin
        // words past capacity are still consumed, just not stored
        imem_we = in_cap;
        state_n = last_word ? DONE : DATA;
      end
      DONE: begin
        if (start) state_n = LEN_LO;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      len_q    <= 16'h0;
      word_cnt <= 16'h0;
      byte_cnt <= 2'd0;
      wdata_q  <= 32'h0;
      addr_q   <= ADDR_INIT;
      hold_q   <= 1'b1;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else if (load) begin
      len_q    <= 16'h0;
      word_cnt <= 16'h0;
      byte_cnt <= 2'd0;
      addr_q   <= ADDR_INIT;
      hold_q   <= 1'b1;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      case (state)
        LEN_LO: begin
          if (in_valid) len_q[7:0] <= in_data;
        end
        LEN_HI: begin
          if (in_valid) begin
            len_q[15:8] <= in_data;
            if (len_hdr == 16'h0) begin
              done_q <= 1'b1;
              hold_q <= 1'b0;
            end
            if (hdr_ovf) ovf_q <= 1'b1;
          end
        end
        DATA: begin
          if (in_valid) begin
            wdata_q[{byte_cnt, 3'b000} +: 8] <= in_data;
            byte_cnt <= byte_cnt + 2'd1;
          end
        end
        WRITE: begin
          if (addr_q != ADDR_MAX) addr_q <= addr_q + 1'b1;
          word_cnt <= word_cnt + 16'd1;
          if (last_word) begin
            done_q <= 1'b1;
            hold_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign cpu_hold   = hold_q;
  assign done       = done_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_imem_stream_loader.sv
// Bench: two loaders (256-word and 4-word memories) on one stream,
// checked every cycle against a stream-position model.
module tb_imem_stream_loader;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [7:0] in_data = 8'h0;
  logic       in_valid = 1'b0;

  logic        rdy8, we8, hold8, done8, ovf8;
  logic [7:0]  addr8;
  logic [31:0] wd8;
  logic        rdy2, we2, hold2, done2, ovf2;
  logic [1:0]  addr2;
  logic [31:0] wd2;

  int nchk = 0;
  int nerr = 0;

  logic [31:0] mem8 [256];
  logic [31:0] mem2 [4];
  int          wc8 = 0;
  int          wc2 = 0;

  typedef logic [7:0] bq_t[$];

  // model: per instance, position in the current image
  bit          m_ld   [2] = '{0, 0};
  bit          m_wp   [2] = '{0, 0};
  bit          m_done [2] = '{0, 0};
  bit          m_hold [2] = '{1, 1};
  bit          m_ovf  [2] = '{0, 0};
  int          m_k    [2] = '{0, 0};
  int          m_n    [2] = '{0, 0};
  int          m_wc   [2] = '{0, 0};
  logic [31:0] m_word [2] = '{32'h0, 32'h0};
  int          caps   [2] = '{256, 4};

  always #5 clk = ~clk;

  imem_stream_loader #(.ADDR_WIDTH(8), .START_ADDR(0)) dut (
    .clk(clk), .reset(reset), .start(start),
    .in_data(in_data), .in_valid(in_valid), .in_ready(rdy8),
    .imem_we(we8), .imem_addr(addr8), .imem_wdata(wd8),
    .cpu_hold(hold8), .done(done8), .overflow(ovf8)
  );

  imem_stream_loader #(.ADDR_WIDTH(2), .START_ADDR(0)) dut_s (
    .clk(clk), .reset(reset), .start(start),
    .in_data(in_data), .in_valid(in_valid), .in_ready(rdy2),
    .imem_we(we2), .imem_addr(addr2), .imem_wdata(wd2),
    .cpu_hold(hold2), .done(done2), .overflow(ovf2)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic m_reset(input int i);
    m_ld[i] = 0; m_wp[i] = 0; m_done[i] = 0; m_hold[i] = 1;
    m_ovf[i] = 0; m_k[i] = 0; m_n[i] = 0; m_wc[i] = 0;
  endtask

  task automatic m_step(input int i);
    int p;
    if (m_wp[i]) begin
      m_wp[i] = 0;
      m_wc[i]++;
      if (m_wc[i] == m_n[i]) begin
        m_ld[i] = 0; m_done[i] = 1; m_hold[i] = 0;
      end
    end else if (m_ld[i]) begin
      if (in_valid) begin
        if (m_k[i] == 0) begin
          m_n[i] = int'(in_data);
        end else if (m_k[i] == 1) begin
          m_n[i] = m_n[i] + (int'(in_data) << 8);
          if (m_n[i] == 0) begin
            m_ld[i] = 0; m_done[i] = 1; m_hold[i] = 0;
          end
          if (m_n[i] > caps[i]) m_ovf[i] = 1;
        end else begin
          p = (m_k[i] - 2) % 4;
          m_word[i][8*p +: 8] = in_data;
          if (p == 3) m_wp[i] = 1;
        end
        m_k[i]++;
      end
    end else if (start) begin
      m_ld[i] = 1; m_k[i] = 0; m_n[i] = 0; m_wc[i] = 0;
      m_done[i] = 0; m_hold[i] = 1; m_ovf[i] = 0;
    end
  endtask

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_reset(0);
      m_reset(1);
    end else begin
      m_step(0);
      m_step(1);
    end
  end

  task automatic cmp(input int i, input logic rdy, input logic we,
                     input int addr, input logic [31:0] wd,
                     input logic hold, input logic dn,
                     input logic ov);
    string sfx;
    bit ewe;
    int ea;
    sfx = (i == 0) ? "/w256" : "/w4";
    ewe = m_wp[i] && (m_wc[i] < caps[i]);
    ea = (m_wc[i] < caps[i] - 1) ? m_wc[i] : caps[i] - 1;
    chk({"in_ready", sfx}, 32'(rdy), 32'(m_ld[i] && !m_wp[i]));
    chk({"imem_we", sfx}, 32'(we), 32'(ewe));
    chk({"imem_addr", sfx}, addr, ea);
    chk({"cpu_hold", sfx}, 32'(hold), 32'(m_hold[i]));
    chk({"done", sfx}, 32'(dn), 32'(m_done[i]));
    chk({"overflow", sfx}, 32'(ov), 32'(m_ovf[i]));
    if (ewe) chk({"imem_wdata", sfx}, wd, m_word[i]);
  endtask

  always @(negedge clk) begin
    cmp(0, rdy8, we8, int'(addr8), wd8, hold8, done8, ovf8);
    cmp(1, rdy2, we2, int'(addr2), wd2, hold2, done2, ovf2);
    if (we8 === 1'b1) begin
      mem8[addr8] = wd8;
      wc8++;
    end
    if (we2 === 1'b1) begin
      mem2[addr2] = wd2;
      wc2++;
    end
  end

  task automatic sync();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_mem();
    for (int a = 0; a < 256; a++) mem8[a] = 32'h0;
    for (int a = 0; a < 4; a++) mem2[a] = 32'h0;
    wc8 = 0;
    wc2 = 0;
  endtask

  task automatic start_load();
    start = 1'b1;
    sync();
    start = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input bit gap);
    int t;
    bit ok;
    t = 0;
    ok = 0;
    in_valid = 1'b1;
    in_data = b;
    while (!ok && t < 40) begin
      @(negedge clk);
      if (rdy8) ok = 1;
      @(posedge clk);
      #2;
      t++;
    end
    in_valid = 1'b0;
    if (!ok) begin
      nchk++;
      nerr++;
      $display("FAIL accept_timeout: byte %h not taken", b);
    end
    if (gap) sync();
  endtask

  task automatic send_seq(input bq_t q, input bit gap);
    foreach (q[j]) send(q[j], gap);
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while (t < 40) begin
      @(negedge clk);
      if (done8 && done2) break;
      t++;
    end
    nchk++;
    if (t >= 40) begin
      nerr++;
      $display("FAIL done_timeout: done %b/%b want 1/1", done8, done2);
    end
    sync();
  endtask

  bq_t basic;
  bq_t q;

  initial begin
    basic = {8'h02, 8'h00, 8'h13, 8'h00, 8'h50, 8'h00,
             8'h93, 8'h00, 8'hA0, 8'h00};
    clear_mem();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 32'(rdy8), 32'h0);
    chk("rst_imem_we", 32'(we8), 32'h0);
    chk("rst_addr", 32'(addr8), 32'h0);
    chk("rst_wdata", wd8, 32'h0);
    chk("rst_cpu_hold", 32'(hold8), 32'h1);
    chk("rst_done", 32'(done8), 32'h0);
    chk("rst_overflow", 32'(ovf8), 32'h0);
    sync();
    reset = 1'b1;
    sync();

    // basic two-word image
    start_load();
    send_seq(basic, 0);
    wait_done();
    chk("basic_w0", mem8[0], 32'h00500013);
    chk("basic_w1", mem8[1], 32'h00A00093);
    chk("basic_nwr", wc8, 2);
    chk("basic_hold", 32'(hold8), 32'h0);

    // zero-length image
    clear_mem();
    start_load();
    q = {8'h00, 8'h00};
    send_seq(q, 0);
    @(negedge clk);
    chk("zero_done_next", 32'(done8), 32'h1);
    chk("zero_hold", 32'(hold8), 32'h0);
    sync();
    repeat (3) sync();
    chk("zero_nwr", wc8, 0);

    // stalled stream
    clear_mem();
    start_load();
    send_seq(basic, 1);
    wait_done();
    chk("stall_w0", mem8[0], 32'h00500013);
    chk("stall_w1", mem8[1], 32'h00A00093);
    chk("stall_nwr", wc8, 2);

    // five words into a four-word memory
    clear_mem();
    start_load();
    q = {8'h05, 8'h00};
    for (int w = 1; w <= 5; w++) begin
      q.push_back(8'(w));
      q.push_back(8'h00);
      q.push_back(8'h00);
      q.push_back(8'h00);
    end
    send_seq(q, 0);
    wait_done();
    for (int w = 0; w < 4; w++) chk("ovf_w4_mem", mem2[w], w + 1);
    chk("ovf_w4_nwr", wc2, 4);
    chk("ovf_w4_flag", 32'(ovf2), 32'h1);
    chk("ovf_w256_flag", 32'(ovf8), 32'h0);
    chk("ovf_w256_w4", mem8[4], 32'h5);
    chk("ovf_w4_addr", 32'(addr2), 32'h3);

    // reset in the middle of a word
    clear_mem();
    start_load();
    q = {8'h02, 8'h00, 8'h13, 8'h00};
    send_seq(q, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_ready", 32'(rdy8), 32'h0);
    chk("midrst_wdata", wd8, 32'h0);
    chk("midrst_hold", 32'(hold8), 32'h1);
    chk("midrst_addr", 32'(addr8), 32'h0);
    sync();
    reset = 1'b1;
    sync();
    chk("midrst_nwr", wc8, 0);
    start_load();
    send_seq(basic, 0);
    wait_done();
    chk("midrst_w0", mem8[0], 32'h00500013);
    chk("midrst_w1", mem8[1], 32'h00A00093);

    // reload after done
    clear_mem();
    start = 1'b1;
    sync();
    start = 1'b0;
    @(negedge clk);
    chk("reload_hold", 32'(hold8), 32'h1);
    chk("reload_done", 32'(done8), 32'h0);
    sync();
    q = {8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    send_seq(q, 0);
    wait_done();
    chk("reload_w0", mem8[0], 32'hDEADBEEF);
    chk("reload_nwr", wc8, 1);
    chk("reload_done1", 32'(done8), 32'h1);

    repeat (2) sync();
    $display("== %0d vectors applied, %0d miscompares ==", nchk, nerr);
    $finish;
  end

endmodule

// File: doc/imem_stream_loader.md
Name: imem_stream_loader

Overview:
- Boot-time writer for the pipelined processor's instruction memory: consumes a byte stream (valid/ready), assembles little-endian 32-bit instruction words, issues one memory write per word.
- Sits between the host/bench byte source and the instruction memory write port.
- Holds the processor core in reset via cpu_hold until a complete program image is loaded, then releases it.

Parameters:
- ADDR_WIDTH, 8, word-address width of instruction memory (depth = 2**ADDR_WIDTH words).
- START_ADDR, 0, word address of first instruction written.

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- start  input  1  single-cycle request to begin a load; honoured only in IDLE or DONE.
- in_data  input  8  stream byte.
- in_valid  input  1  in_data valid.
- in_ready  output  1  loader accepts byte this cycle (transfer = in_valid & in_ready).
- imem_we  output  1  instruction memory write strobe, one cycle per word.
- imem_addr  output  ADDR_WIDTH  word address for write.
- imem_wdata  output  32  instruction word.
- cpu_hold  output  1  1 = keep processor in reset.
- done  output  1  image fully loaded.
- overflow  output  1  sticky: header count exceeded memory depth.

Behaviour:
- Reset (async, reset=0): state IDLE; in_ready=0, imem_we=0, imem_addr=START_ADDR, imem_wdata=0, cpu_hold=1, done=0, overflow=0; byte counter, word counter, count register cleared. Reset mid-load abandons the partial word; no write issued.
- Stream format: 2-byte header N (word count, low byte first), then 4*N bytes, each word little-endian (first byte -> bits 7:0).
- States: IDLE, LEN_LO, LEN_HI, DATA, WRITE, DONE.
- IDLE: in_ready=0. start -> LEN_LO; cpu_hold=1, done=0, overflow=0, imem_addr=START_ADDR.
- LEN_LO: in_ready=1; on transfer latch N[7:0] -> LEN_HI.
- LEN_HI: in_ready=1; on transfer latch N[15:8]. If N==0 -> DONE. Else -> DATA. If N > 2**ADDR_WIDTH - START_ADDR, set overflow.
- DATA: in_ready=1; each transfer shifts byte into word at position byte_cnt (0..3). On 4th byte -> WRITE.
- WRITE: in_ready=0; imem_we=1 for exactly this cycle with assembled word and current imem_addr. Words whose index exceeds capacity: imem_we held 0 (bytes consumed, discarded). Next cycle: imem_addr+1 (saturates at max, no wrap), word_cnt+1; if word_cnt+1==N -> DONE else DATA.
- Latency: 4th byte accepted at cycle T -> imem_we asserted at T+1 -> next byte acceptable at T+2.
- DONE: in_ready=0, done=1, cpu_hold=0 (registered, first DONE cycle). Bytes presented are ignored. start -> LEN_LO, cpu_hold=1 same edge, done=0.
- start outside IDLE/DONE ignored. in_valid low stalls any state with no side effects.
- No byte is accepted while in_ready=0; counters use full-width compare, no wrap of word_cnt (16 bits).

Test Plan:
- Basic load: start, stream 02 00, 13 00 50 00, 93 00 A0 00 -> writes addr0=00500013, addr1=00A00093; done=1, cpu_hold 1->0 after 2nd write.
- Zero-length: header 00 00 -> DONE in cycle after 2nd header byte, no imem_we, cpu_hold=0.
- Backpressure/stall: in_valid toggled every other cycle during DATA -> same words/addresses as basic; in_ready=0 exactly on each WRITE cycle.
- Overflow (ADDR_WIDTH=2): N=5 with words 1..5 -> addresses 0..3 written with words 1..4, 5th word consumed with no write, overflow=1, done=1.
- Reset mid-word: after 2 data bytes assert reset=0 for 1 cycle -> all outputs at reset values, no write; fresh start reloads correctly from START_ADDR.
- Reload: after DONE, start and load 1 word DEADBEEF -> cpu_hold reasserts on start edge, addr0=DEADBEEF, done re-asserts.
